// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Each operation takes 33 cycles: 32 shift-add or restoring-divide steps, then one sign-fix step.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        hiWrite,
    input  logic        loWrite,
    input  logic [31:0] wrData,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state_reg;
    logic [1:0]  op_reg;
    logic [31:0] a_raw_reg;
    logic [31:0] opnd_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] acc_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // Operand magnitudes; unsigned ops pass operands through unchanged.
    logic        start_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        start_signed = ~op[0];
        abs_a = (start_signed && srcA[31]) ? (32'd0 - srcA) : srcA;
        abs_b = (start_signed && srcB[31]) ? (32'd0 - srcB) : srcB;
    end

    // One iteration step. acc_reg holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] iter_next;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        mul_next  = {mul_sum, acc_reg[31:1]};
        div_shift = acc_reg[63:31];
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_next  = div_diff[32] ? {div_shift[31:0], acc_reg[30:0], 1'b0}
                                 : {div_diff[31:0],  acc_reg[30:0], 1'b1};
        iter_next = op_reg[1] ? div_next : mul_next;
    end

    // Sign correction and result mapping applied in FIX.
    logic        fix_signed;
    logic        neg_result;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        fix_signed = ~op_reg[0];
        neg_result = fix_signed && (sign_a_reg ^ sign_b_reg);
        prod_fix   = neg_result ? (64'd0 - acc_reg) : acc_reg;
        quo_fix    = neg_result ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
        rem_fix    = (fix_signed && sign_a_reg) ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
        if (!op_reg[1]) begin
            fix_hi = prod_fix[63:32];
            fix_lo = prod_fix[31:0];
        end else if (opnd_reg == 32'd0) begin
            fix_hi = a_raw_reg;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= 2'd0;
            a_raw_reg  <= 32'd0;
            opnd_reg   <= 32'd0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            cnt_reg    <= 5'd0;
            acc_reg    <= 64'd0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hiWrite) hi_reg <= wrData;
                    if (loWrite) lo_reg <= wrData;
                    if (start) begin
                        state_reg  <= CALC;
                        op_reg     <= op;
                        a_raw_reg  <= srcA;
                        opnd_reg   <= abs_b;
                        sign_a_reg <= srcA[31];
                        sign_b_reg <= srcB[31];
                        cnt_reg    <= 5'd0;
                        acc_reg    <= {32'd0, abs_a};
                    end
                end
                CALC: begin
                    acc_reg <= iter_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner-case sequences and random ops vs a reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] wrData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .hiWrite(hiWrite), .loWrite(loWrite),
        .wrData(wrData), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Architectural results computed directly from the instruction definitions.
    task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rhi, output logic [31:0] rlo);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
            2'b01: begin p = ua * ub; rhi = p[63:32]; rlo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    rhi = a;
                    rlo = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = 64'(sq); rlo = p[31:0];
                    p = 64'(sr); rhi = p[31:0];
                end else begin
                    rlo = a / b;
                    rhi = a % b;
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge just after E33 (done cycle).
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit disturb);
        bit early_done = 0;
        bit not_busy = 0;
        bit unstable = 0;
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) early_done = 1;
            if (!busy) not_busy = 1;
            if (hi !== model_hi || lo !== model_lo) unstable = 1;
            if (disturb && k == 5) begin
                start = 1'b1; op = 2'b01; srcA = 32'h0000_1234; srcB = 32'h0000_5678;
                hiWrite = 1'b1; wrData = 32'hDEAD_BEEF;
            end else if (disturb && k == 6) begin
                start = 1'b0; hiWrite = 1'b0;
            end
        end
        check({name, " done early"}, 64'(early_done), 64'd0);
        check({name, " busy during calc"}, 64'(not_busy), 64'd0);
        check({name, " hi/lo held"}, 64'(unstable), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, " done at E33"}, 64'(done), 64'd1);
        check({name, " busy at E33"}, 64'(busy), 64'd0);
        check({name, " hi"}, 64'(hi), 64'(eh));
        check({name, " lo"}, 64'(lo), 64'(el));
        model_hi = eh;
        model_lo = el;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (%s)", o, a, b, hi, lo, name);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 20)));
            default: return 32'($urandom);
        endcase
    endfunction

    vec_t vecs[8];

    initial begin
        logic [31:0] rh;
        logic [31:0] rl;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          saw_done;

        vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; srcA = 32'd0; srcB = 32'd0;
        hiWrite = 1'b0; loWrite = 1'b0; wrData = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of CALC discards the operation.
        op = 2'b01; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midcalc reset busy", 64'(busy), 64'd0);
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("midcalc reset no done", 64'(saw_done), 64'd0);
        check("midcalc reset hi", 64'(hi), 64'd0);
        check("midcalc reset lo", 64'(lo), 64'd0);

        // Directed table; consecutive entries start in the done cycle (back-to-back).
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);

        // start/MTHI during CALC must be ignored.
        @(negedge clk);
        run_op("busy protect", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
        check("busy protect not deadbeef", 64'(hi == 32'hDEAD_BEEF), 64'd0);
        @(negedge clk);
        check("no restart after protect", 64'(busy), 64'd0);

        loWrite = 1'b1; wrData = 32'hCAFE_F00D;
        @(negedge clk);
        loWrite = 1'b0;
        check("mtlo lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo hi kept", 64'(hi), 64'd0);
        hiWrite = 1'b1; loWrite = 1'b1; wrData = 32'h0BAD_F00D;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h0BAD_F00D);
        check("mthi+mtlo lo", 64'(lo), 64'h0BAD_F00D);
        model_hi = 32'h0BAD_F00D;
        model_lo = 32'h0BAD_F00D;

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            ref_model(ro, ra, rb, rh, rl);
            run_op($sformatf("rand%0d", i), ro, ra, rb, rh, rl, 1'b0);
        end

        @(negedge clk);
        check("final done low", 64'(done), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
